// File: rtl/cc_pkg.sv
// Shared types for the snooping MESI bus controller: end states, bus FSM
// encoding and the requester end-state rule.
package cc_pkg;

  localparam int BLOCK_SIZE = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    MODIFIED  = 2'd0,
    EXCLUSIVE = 2'd1,
    SHARED    = 2'd2,
    INVALID   = 2'd3
  } cc_end_state;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_SNOOP,
    BUS_WB,
    BUS_MEM_RD,
    BUS_RESP
  } cc_bus_state_t;

  // A write always ends owned; a read is shared only if someone else holds the line.
  function automatic cc_end_state requester_state(input logic is_write, input logic any_hit);
    if (is_write) return MODIFIED;
    return any_hit ? SHARED : EXCLUSIVE;
  endfunction

endpackage

// File: rtl/cc_rr_arbiter.sv
// N-way round-robin arbiter; the pointer moves past the last served cache
// when the bus controller finishes a transaction.
module cc_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] last_idx,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (int'(last_idx) == N - 1) ? '0 : last_idx + 1'b1;
    end
  end

  // Scan from the furthest offset back to the pointer so the nearest requester wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr_reg) + k) % N]) gnt_idx = IW'((int'(ptr_reg) + k) % N);
    end
  end

endmodule

// File: rtl/cc_snoop_bus.sv
// Snooping MESI bus controller: arbitrates L1 misses, snoops the other caches,
// sources the block cache-to-cache or from memory, writing back dirty hits first.
module cc_snoop_bus #(
  parameter int N_CACHES   = 2,
  parameter int BLOCK_SIZE = cc_pkg::BLOCK_SIZE
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_CACHES-1:0]          req_valid,
  input  logic [N_CACHES-1:0]          req_write,
  input  logic [N_CACHES*32-1:0]       req_addr,
  output logic [N_CACHES-1:0]          resp_valid,
  output logic [32*BLOCK_SIZE-1:0]     resp_data,
  output logic [1:0]                   resp_state,
  output logic [N_CACHES-1:0]          snoop_req,
  output logic [31:0]                  snoop_addr,
  output logic [1:0]                   snoop_state,
  input  logic [N_CACHES-1:0]          snoop_busy,
  input  logic [N_CACHES-1:0]          snoop_hit,
  input  logic [N_CACHES-1:0]          snoop_dirty,
  input  logic [N_CACHES*32*BLOCK_SIZE-1:0] snoop_data,
  output logic                         mem_ren,
  output logic                         mem_wen,
  output logic [31:0]                  mem_addr,
  output logic [32*BLOCK_SIZE-1:0]     mem_wdata,
  input  logic [32*BLOCK_SIZE-1:0]     mem_rdata,
  input  logic                         mem_ready
);
  import cc_pkg::*;

  localparam int BW = 32 * BLOCK_SIZE;
  localparam int IW = $clog2(N_CACHES);
  localparam logic [N_CACHES-1:0] ONE = N_CACHES'(1);

  cc_bus_state_t         state_reg;
  logic [IW-1:0]         g_reg;
  word_t                 addr_reg;
  logic                  write_reg;
  logic                  hit_reg;
  logic [N_CACHES-1:0]   resp_valid_reg;
  logic [BW-1:0]         resp_data_reg;
  cc_end_state           resp_state_reg;
  logic [N_CACHES-1:0]   snoop_req_reg;
  word_t                 snoop_addr_reg;
  cc_end_state           snoop_state_reg;
  logic                  mem_ren_reg;
  logic                  mem_wen_reg;
  word_t                 mem_addr_reg;
  logic [BW-1:0]         mem_wdata_reg;

  logic                  gnt_valid;
  logic [IW-1:0]         gnt_idx;
  word_t                 gnt_addr;
  logic [BW-1:0]         snoop_blk [N_CACHES];
  logic [N_CACHES-1:0]   others;
  logic [N_CACHES-1:0]   hit_m;
  logic [N_CACHES-1:0]   dirty_m;
  logic [IW-1:0]         hit_idx;
  logic [IW-1:0]         dirty_idx;
  logic                  snoop_free;

  cc_rr_arbiter #(.N(N_CACHES), .IW(IW)) u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req_valid),
    .advance  (state_reg == BUS_RESP),
    .last_idx (g_reg),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  for (genvar gi = 0; gi < N_CACHES; gi++) begin : g_unpack
    assign snoop_blk[gi] = snoop_data[gi*BW +: BW];
  end

  assign gnt_addr   = req_addr[gnt_idx*32 +: 32];
  assign others     = ~(ONE << g_reg);
  assign hit_m      = snoop_hit & others;
  assign dirty_m    = hit_m & snoop_dirty;
  // The requester's own busy bit never delays the snoop.
  assign snoop_free = ~|(snoop_busy & others);

  always_comb begin
    hit_idx   = '0;
    dirty_idx = '0;
    for (int i = N_CACHES - 1; i >= 0; i--) begin
      if (hit_m[i])   hit_idx   = IW'(i);
      if (dirty_m[i]) dirty_idx = IW'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= BUS_IDLE;
      g_reg           <= '0;
      addr_reg        <= '0;
      write_reg       <= 1'b0;
      hit_reg         <= 1'b0;
      resp_valid_reg  <= '0;
      resp_data_reg   <= '0;
      resp_state_reg  <= MODIFIED;
      snoop_req_reg   <= '0;
      snoop_addr_reg  <= '0;
      snoop_state_reg <= MODIFIED;
      mem_ren_reg     <= 1'b0;
      mem_wen_reg     <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
    end else begin
      case (state_reg)
        BUS_IDLE: begin
          if (gnt_valid) begin
            g_reg           <= gnt_idx;
            addr_reg        <= gnt_addr;
            write_reg       <= req_write[gnt_idx];
            snoop_req_reg   <= ~(ONE << gnt_idx);
            snoop_addr_reg  <= gnt_addr;
            snoop_state_reg <= req_write[gnt_idx] ? INVALID : SHARED;
            state_reg       <= BUS_SNOOP;
          end
        end
        BUS_SNOOP: begin
          if (snoop_free) begin
            snoop_req_reg <= '0;
            hit_reg       <= |hit_m;
            if (|dirty_m) begin
              // The written-back block doubles as the forwarded block.
              mem_wen_reg   <= 1'b1;
              mem_addr_reg  <= addr_reg;
              mem_wdata_reg <= snoop_blk[dirty_idx];
              state_reg     <= BUS_WB;
            end else if (|hit_m) begin
              resp_valid_reg <= ONE << g_reg;
              resp_data_reg  <= snoop_blk[hit_idx];
              resp_state_reg <= requester_state(write_reg, 1'b1);
              state_reg      <= BUS_RESP;
            end else begin
              mem_ren_reg  <= 1'b1;
              mem_addr_reg <= addr_reg;
              state_reg    <= BUS_MEM_RD;
            end
          end
        end
        BUS_WB: begin
          if (mem_ready) begin
            mem_wen_reg    <= 1'b0;
            resp_valid_reg <= ONE << g_reg;
            resp_data_reg  <= mem_wdata_reg;
            resp_state_reg <= requester_state(write_reg, hit_reg);
            state_reg      <= BUS_RESP;
          end
        end
        BUS_MEM_RD: begin
          if (mem_ready) begin
            mem_ren_reg    <= 1'b0;
            resp_valid_reg <= ONE << g_reg;
            resp_data_reg  <= mem_rdata;
            resp_state_reg <= requester_state(write_reg, 1'b0);
            state_reg      <= BUS_RESP;
          end
        end
        BUS_RESP: begin
          resp_valid_reg <= '0;
          state_reg      <= BUS_IDLE;
        end
        default: state_reg <= BUS_IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_reg;
  assign resp_data   = resp_data_reg;
  assign resp_state  = resp_state_reg;
  assign snoop_req   = snoop_req_reg;
  assign snoop_addr  = snoop_addr_reg;
  assign snoop_state = snoop_state_reg;
  assign mem_ren     = mem_ren_reg;
  assign mem_wen     = mem_wen_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_cc_snoop_bus.sv
// Randomized bench for cc_snoop_bus: the bench plays caches and memory and
// predicts grant order, data source, end state and latency from the protocol rules.
module tb_cc_snoop_bus;
  import cc_pkg::*;

  localparam int N  = 2;
  localparam int BW = 32 * BLOCK_SIZE;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N-1:0]      req_valid, req_write;
  logic [N*32-1:0]   req_addr;
  logic [N-1:0]      resp_valid;
  logic [BW-1:0]     resp_data;
  logic [1:0]        resp_state;
  logic [N-1:0]      snoop_req;
  logic [31:0]       snoop_addr;
  logic [1:0]        snoop_state;
  logic [N-1:0]      snoop_busy, snoop_hit, snoop_dirty;
  logic [N*BW-1:0]   snoop_data;
  logic              mem_ren, mem_wen;
  logic [31:0]       mem_addr;
  logic [BW-1:0]     mem_wdata, mem_rdata;
  logic              mem_ready;

  cc_snoop_bus #(.N_CACHES(N), .BLOCK_SIZE(BLOCK_SIZE)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_state(resp_state),
    .snoop_req(snoop_req), .snoop_addr(snoop_addr), .snoop_state(snoop_state),
    .snoop_busy(snoop_busy), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
    .snoop_data(snoop_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_txn    = 0;
  int            rr_ptr;
  int            busy_n, mem_lat;
  logic [N-1:0]  pending;
  logic [31:0]   addr_of [N];
  logic          wr_of [N];
  logic [BW-1:0] blk_of [N];

  always @(posedge CLK) begin
    if (!RST && snoop_req != '0)
      assert ($countones(snoop_req & snoop_hit & snoop_dirty) <= 1)
        else $error("protocol error: more than one dirty snoop hit");
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int w = 0; w < BLOCK_SIZE; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_resp_valid"}, resp_valid, '0);
    check({tag, "_snoop_req"}, snoop_req, '0);
    check({tag, "_mem_strobes"}, {mem_ren, mem_wen}, '0);
    check({tag, "_resp_data"}, resp_data, '0);
    check({tag, "_resp_state"}, resp_state, MODIFIED);
    check({tag, "_snoop_state"}, snoop_state, MODIFIED);
    check({tag, "_addrs"}, {snoop_addr, mem_addr}, '0);
    check({tag, "_mem_wdata"}, mem_wdata, '0);
  endtask

  task automatic new_req(input int i, input logic wr, input logic [31:0] a);
    pending[i]          = 1'b1;
    req_valid[i]        = 1'b1;
    req_write[i]        = wr;
    req_addr[i*32 +: 32] = a;
    wr_of[i]            = wr;
    addr_of[i]          = a;
  endtask

  task automatic set_cfg(input logic [N-1:0] hit, input logic [N-1:0] dirty, input int busy, input int lat);
    snoop_hit   = hit;
    snoop_dirty = dirty;
    busy_n      = busy;
    mem_lat     = lat;
    for (int i = 0; i < N; i++) begin
      blk_of[i] = rand_block();
      snoop_data[i*BW +: BW] = blk_of[i];
    end
  endtask

  task automatic rand_cfg(input int g);
    logic [N-1:0] h, d;
    int dcount;
    dcount = 0;
    for (int i = 0; i < N; i++) begin
      h[i] = $urandom_range(0, 1);
      d[i] = h[i] && ($urandom_range(0, 2) == 0) && (i == g || dcount == 0);
      if (d[i] && i != g) dcount++;
    end
    set_cfg(h, d, $urandom_range(0, 3), $urandom_range(1, 4));
  endtask

  // Called at a falling edge where the next rising edge sees the bus idle and req_valid[g] set.
  task automatic run_one(input int g);
    logic [N-1:0]  g_mask, others, hitset, dirtyset;
    logic [BW-1:0] exp_data, mem_word;
    logic [1:0]    exp_state;
    int            path, exp_cycles, cyc, snoop_cyc, ren_cyc, wen_cyc;
    bit            done;
    g_mask   = N'(1) << g;
    others   = ~g_mask;
    hitset   = snoop_hit & others;
    dirtyset = snoop_hit & snoop_dirty & others;
    mem_word = rand_block();
    exp_data = mem_word;
    path     = 2;
    for (int i = N - 1; i >= 0; i--)
      if (hitset[i]) begin exp_data = blk_of[i]; path = 0; end
    if (dirtyset != '0) begin
      path = 1;
      for (int i = N - 1; i >= 0; i--) if (dirtyset[i]) exp_data = blk_of[i];
    end
    exp_state  = wr_of[g] ? MODIFIED : (hitset != '0 ? SHARED : EXCLUSIVE);
    exp_cycles = 2 + busy_n + (path == 0 ? 0 : mem_lat);
    cyc = 0; snoop_cyc = 0; ren_cyc = 0; wen_cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      check("mem_both", mem_ren & mem_wen, 1'b0);
      if (snoop_req != '0) begin
        snoop_cyc++;
        check("snoop_req", snoop_req, others);
        check("snoop_addr", snoop_addr, addr_of[g]);
        check("snoop_state", snoop_state, wr_of[g] ? INVALID : SHARED);
      end
      if (mem_wen) begin
        wen_cyc++;
        check("wb_addr", mem_addr, addr_of[g]);
        check("wb_data", mem_wdata, exp_data);
      end
      if (mem_ren) begin
        ren_cyc++;
        check("rd_addr", mem_addr, addr_of[g]);
      end
      if (resp_valid != '0) begin
        done = 1;
        check("resp_valid", resp_valid, g_mask);
        check("resp_data", resp_data, exp_data);
        check("resp_state", resp_state, exp_state);
        check("latency", cyc, exp_cycles);
        check("snoop_cycles", snoop_cyc, busy_n + 1);
        check("wen_cycles", wen_cyc, path == 1 ? mem_lat : 0);
        check("ren_cycles", ren_cyc, path == 2 ? mem_lat : 0);
        req_valid[g] = 1'b0;
      end
      snoop_busy = (g_mask & N'($urandom_range(0, 3))) |
                   ((snoop_req != '0 && snoop_cyc <= busy_n) ? others : '0);
      mem_ready  = (mem_ren | mem_wen) && (ren_cyc + wen_cyc >= mem_lat);
      mem_rdata  = mem_ready ? mem_word : rand_block();
    end
    n_txn++;
    $display("txn %0d: cache %0d %s addr %h path %0d busy %0d lat %0d cycles %0d",
             n_txn, g, wr_of[g] ? "wr" : "rd", addr_of[g], path, busy_n, mem_lat, cyc);
    if (!done) begin
      check("resp_timeout", 1'b0, 1'b1);
      RST = 1'b1; req_valid = '0; pending = '0;
      @(negedge CLK);
      RST = 1'b0;
      rr_ptr = 0;
    end else begin
      @(negedge CLK);
      check("resp_pulse", resp_valid, '0);
      check("idle_strobes", {snoop_req, mem_ren, mem_wen}, '0);
      pending[g] = 1'b0;
      rr_ptr = (g + 1) % N;
    end
  endtask

  task automatic serve_pending();
    int g;
    while (pending != '0) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pending[(rr_ptr + k) % N]) g = (rr_ptr + k) % N;
      rand_cfg(g);
      run_one(g);
    end
  endtask

  task automatic directed(input int g, input logic wr, input logic [31:0] a,
                          input logic [N-1:0] hit, input logic [N-1:0] dirty,
                          input int busy, input int lat);
    new_req(g, wr, a);
    set_cfg(hit, dirty, busy, lat);
    run_one(g);
  endtask

  initial begin
    int cnt;
    RST = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0;
    snoop_busy = '0; snoop_hit = '0; snoop_dirty = '0; snoop_data = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    pending = '0; rr_ptr = 0; busy_n = 0; mem_lat = 1;
    repeat (3) @(negedge CLK);
    check_quiet("reset");
    RST = 1'b0;

    // Simultaneous requests straight out of reset: cache0 first, then cache1.
    new_req(0, 1'b0, 32'h0000_0500);
    new_req(1, 1'b1, 32'h0000_0600);
    serve_pending();

    directed(0, 1'b0, 32'h0000_0100, 2'b00, 2'b00, 0, 3);
    directed(1, 1'b0, 32'h0000_0200, 2'b01, 2'b00, 0, 1);
    directed(0, 1'b1, 32'h0000_0300, 2'b10, 2'b10, 0, 2);
    directed(0, 1'b0, 32'h0000_0400, 2'b00, 2'b00, 4, 1);
    directed(1, 1'b1, 32'h0000_0700, 2'b11, 2'b00, 1, 1);

    // Reset in the middle of a memory read; the held request must then complete.
    new_req(0, 1'b0, 32'h0000_0100);
    set_cfg(2'b00, 2'b00, 0, 2);
    snoop_busy = '0; mem_ready = 1'b0;
    cnt = 0;
    while (!mem_ren && cnt < 20) begin
      @(negedge CLK);
      cnt++;
    end
    check("rst_setup_ren", mem_ren, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_quiet("rst_mid");
    rr_ptr = 0;
    set_cfg(2'b00, 2'b00, 0, 2);
    run_one(0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) new_req(i, 1'($urandom_range(0, 1)), $urandom);
      if (pending == '0) new_req($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom);
      serve_pending();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
